// File: rtl/alu_exec_ctrl_if.sv
// alu_exec_ctrl_if: request (valid/ready), ALU drive/return and response (valid/ready) signals; slave = controller, master = environment
interface alu_exec_ctrl_if #(parameter int SHAMT_W = 4);
  logic               req_valid;
  logic               req_ready;
  logic [2:0]         req_op;
  logic [15:0]        req_a;
  logic [15:0]        req_b;
  logic [SHAMT_W-1:0] req_shamt;
  logic               req_setf;
  logic [15:0]        alu_a;
  logic [15:0]        alu_b;
  logic [2:0]         alu_op;
  logic [15:0]        alu_o;
  logic               alu_fc;
  logic               alu_fv;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [15:0]        rsp_result;
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_shamt, req_setf, alu_o, alu_fc, alu_fv, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result
  );
  modport master (
    output req_valid, req_op, req_a, req_b, req_shamt, req_setf, alu_o, alu_fc, alu_fv, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: execute-stage controller for a 1-bit-shift ALU; ports clk, rst, bus (req/alu/rsp), flags {Z,C,N,V}, busy
module alu_exec_ctrl #(parameter int SHAMT_W = 4) (
  input  logic                 clk,
  input  logic                 rst,
  alu_exec_ctrl_if.slave       bus,
  output logic [3:0]           flags,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_t;
  state_t             r_state;
  logic [2:0]         r_op;
  logic [15:0]        r_a;
  logic [15:0]        r_b;
  logic [15:0]        r_acc;
  logic [15:0]        r_result;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_setf;
  logic [3:0]         r_flags;
  logic [3:0]         w_flags;
  logic               w_shift;
  assign w_flags        = {bus.alu_o == 16'h0, bus.alu_fc, bus.alu_o[15], bus.alu_fv};
  assign w_shift        = bus.req_op[2:1] == 2'b11;
  assign bus.req_ready  = r_state == IDLE;
  assign bus.rsp_valid  = r_state == RESP;
  assign bus.rsp_result = r_result;
  assign bus.alu_a      = r_state == EXEC ? r_a : r_state == SHIFT ? r_acc : 16'h0;
  assign bus.alu_b      = r_state == EXEC ? r_b : 16'h0;
  assign bus.alu_op     = (r_state == EXEC || r_state == SHIFT) ? r_op : 3'b000;
  assign flags          = r_flags;
  assign busy           = r_state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= 3'b000;
      r_a      <= 16'h0;
      r_b      <= 16'h0;
      r_acc    <= 16'h0;
      r_result <= 16'h0;
      r_cnt    <= '0;
      r_setf   <= 1'b0;
      r_flags  <= 4'h0;
    end else begin
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_op   <= bus.req_op;
          r_a    <= bus.req_a;
          r_b    <= bus.req_b;
          r_acc  <= bus.req_a;
          r_cnt  <= bus.req_shamt;
          r_setf <= bus.req_setf;
          if (!w_shift) r_state <= EXEC;
          else if (bus.req_shamt == '0) begin
            // zero-length shift bypasses the ALU entirely
            r_result <= bus.req_a;
            if (bus.req_setf) r_flags <= {bus.req_a == 16'h0, 1'b0, bus.req_a[15], 1'b0};
            r_state  <= RESP;
          end else r_state <= SHIFT;
        end
        EXEC: begin
          r_result <= bus.alu_o;
          if (r_setf) r_flags <= w_flags;
          r_state  <= RESP;
        end
        SHIFT: begin
          r_acc <= bus.alu_o;
          r_cnt <= r_cnt - SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(1)) begin
            r_result <= bus.alu_o;
            if (r_setf) r_flags <= w_flags;
            r_state  <= RESP;
          end
        end
        RESP: if (bus.rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: vector table, hand sequences and random ops against a reference model
module tb_alu_exec_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] flags;
  logic       busy;
  int         n_pass = 0;
  int         n_total = 0;
  alu_exec_ctrl_if bus();
  alu_exec_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave), .flags(flags), .busy(busy));
  always #5 clk = ~clk;
  // environment ALU: SUB carry means no borrow, shifts move one bit per pass
  always_comb begin
    bus.alu_o  = 16'h0;
    bus.alu_fc = 1'b0;
    bus.alu_fv = 1'b0;
    case (bus.alu_op)
      3'd0: begin
        {bus.alu_fc, bus.alu_o} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_fv = (bus.alu_a[15] == bus.alu_b[15]) && (bus.alu_o[15] != bus.alu_a[15]);
      end
      3'd1: begin
        bus.alu_o  = bus.alu_a - bus.alu_b;
        bus.alu_fc = bus.alu_a >= bus.alu_b;
        bus.alu_fv = (bus.alu_a[15] != bus.alu_b[15]) && (bus.alu_o[15] != bus.alu_a[15]);
      end
      3'd2: bus.alu_o = bus.alu_a & bus.alu_b;
      3'd3: bus.alu_o = bus.alu_a | bus.alu_b;
      3'd4: bus.alu_o = ~bus.alu_a;
      3'd5: bus.alu_o = bus.alu_a ^ bus.alu_b;
      3'd6: bus.alu_o = {1'b0, bus.alu_a[15:1]};
      default: bus.alu_o = {bus.alu_a[14:0], 1'b0};
    endcase
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] sh,
                       input logic setf, input int hold, output logic [15:0] res, output logic [3:0] fl, output int lat);
    @(negedge clk);
    check("req_ready idle", bus.req_ready, 1);
    bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_shamt = sh; bus.req_setf = setf; bus.req_valid = 1'b1;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.rsp_result;
    fl  = flags;
    repeat (hold) @(posedge clk);
    @(negedge clk) bus.rsp_ready = 1'b1;
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
  endtask
  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  sh;
    logic        setf;
    logic [15:0] res;
    logic [3:0]  fl;
    int          lat;
  } vec_t;
  vec_t tbl[10];
  initial begin
    logic [15:0] res, er, a, b;
    logic [3:0]  fl, mflags, sh;
    logic [2:0]  op;
    logic        setf, c, v;
    int          lat, stray, sa, sb, d;
    tbl[0] = '{3'd0, 16'h7FFF, 16'h0001, 4'd0,  1'b1, 16'h8000, 4'b0011, 2};
    tbl[1] = '{3'd0, 16'hFFFF, 16'h0001, 4'd0,  1'b1, 16'h0000, 4'b1100, 2};
    tbl[2] = '{3'd2, 16'h00F0, 16'h0F00, 4'd0,  1'b0, 16'h0000, 4'b1100, 2};
    tbl[3] = '{3'd7, 16'h0001, 16'hAAAA, 4'd15, 1'b1, 16'h8000, 4'b0010, 16};
    tbl[4] = '{3'd6, 16'h1234, 16'h5555, 4'd0,  1'b1, 16'h1234, 4'b0000, 1};
    tbl[5] = '{3'd6, 16'h8000, 16'h0000, 4'd4,  1'b1, 16'h0800, 4'b0000, 5};
    tbl[6] = '{3'd1, 16'h8000, 16'h0001, 4'd0,  1'b1, 16'h7FFF, 4'b0101, 2};
    tbl[7] = '{3'd4, 16'h00FF, 16'h1234, 4'd0,  1'b1, 16'hFF00, 4'b0010, 2};
    tbl[8] = '{3'd3, 16'h1200, 16'h0034, 4'd0,  1'b1, 16'h1234, 4'b0000, 2};
    tbl[9] = '{3'd5, 16'hFFFF, 16'hFFFF, 4'd0,  1'b1, 16'h0000, 4'b1000, 2};
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_a = 16'h0; bus.req_b = 16'h0;
    bus.req_shamt = 4'd0; bus.req_setf = 1'b0; bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", bus.req_ready, 1);
    check("reset busy", busy, 0);
    check("reset rsp_valid", bus.rsp_valid, 0);
    check("reset rsp_result", bus.rsp_result, 0);
    check("reset flags", flags, 0);
    check("reset alu_a", bus.alu_a, 0);
    check("reset alu_op", bus.alu_op, 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, tbl[i].setf, i % 3, res, fl, lat);
      check($sformatf("vec%0d result", i), res, tbl[i].res);
      check($sformatf("vec%0d flags", i), fl, tbl[i].fl);
      check($sformatf("vec%0d latency", i), lat, tbl[i].lat);
    end
    @(negedge clk);
    bus.req_op = 3'd0; bus.req_a = 16'd1; bus.req_b = 16'd2; bus.req_shamt = 4'd0; bus.req_setf = 1'b1; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_op = 3'd1; bus.req_a = 16'd5; bus.req_b = 16'd3; bus.req_setf = 1'b0;
    @(posedge clk); #1;
    check("bp rsp_valid", bus.rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d rsp_valid", i), bus.rsp_valid, 1);
      check($sformatf("bp%0d result", i), bus.rsp_result, 16'd3);
      check($sformatf("bp%0d flags", i), flags, 4'b0000);
      check($sformatf("bp%0d req_ready", i), bus.req_ready, 0);
    end
    @(negedge clk) bus.rsp_ready = 1'b1;
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    check("bp release rsp_valid", bus.rsp_valid, 0);
    check("bp release req_ready", bus.req_ready, 1);
    @(posedge clk); #1 bus.req_valid = 1'b0;
    check("bp second accept busy", busy, 1);
    @(posedge clk); #1;
    check("bp second rsp_valid", bus.rsp_valid, 1);
    check("bp second result", bus.rsp_result, 16'd2);
    check("bp second flags", flags, 4'b0000);
    @(negedge clk) bus.rsp_ready = 1'b1;
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    do_op(3'd0, 16'hFFFF, 16'h0001, 4'd0, 1'b1, 0, res, fl, lat);
    check("pre-reset flags", fl, 4'b1100);
    @(negedge clk);
    bus.req_op = 3'd7; bus.req_a = 16'h0001; bus.req_shamt = 4'd10; bus.req_setf = 1'b1; bus.req_valid = 1'b1;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("mid-shift busy", busy, 1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("abort busy", busy, 0);
    check("abort rsp_valid", bus.rsp_valid, 0);
    check("abort flags", flags, 0);
    check("abort req_ready", bus.req_ready, 1);
    @(negedge clk) rst = 1'b0;
    stray = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.rsp_valid || busy) stray++;
    end
    check("abort no stray response", stray, 0);
    mflags = 4'h0;
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (i % 7 == 0) a = 16'h8000;
      if (i % 11 == 0) b = 16'hFFFF;
      sh   = 4'($urandom_range(0, 15));
      setf = 1'($urandom_range(0, 1));
      sa = $signed(a);
      sb = $signed(b);
      c = 1'b0;
      v = 1'b0;
      case (op)
        3'd0: begin d = sa + sb; er = a + b; c = (32'(a) + 32'(b)) > 65535; v = d > 32767 || d < -32768; end
        3'd1: begin d = sa - sb; er = a - b; c = a >= b; v = d > 32767 || d < -32768; end
        3'd2: er = a & b;
        3'd3: er = a | b;
        3'd4: er = ~a;
        3'd5: er = a ^ b;
        3'd6: er = a >> sh;
        default: er = a << sh;
      endcase
      if (setf) mflags = {er == 16'h0, c, er[15], v};
      do_op(op, a, b, sh, setf, $urandom_range(0, 3), res, fl, lat);
      check($sformatf("rnd%0d op%0d result", i, op), res, er);
      check($sformatf("rnd%0d op%0d flags", i, op), fl, mflags);
      check($sformatf("rnd%0d op%0d latency", i, op), lat, op[2:1] == 2'b11 ? sh + 1 : 2);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Execute-stage controller that drives the 16-bit combinational ALU: accepts one operation over a valid/ready request port, presents operands and opcode to the ALU, and captures the result. It holds the result on a valid/ready response port and keeps the architectural Z/C/N/V flag register. The ALU shifts only 1 bit per pass, so multi-bit LSR/LSL run as a counted loop through the ALU.

Parameters:
SHAMT_W, 4, width of shift-amount field (max shift 2^SHAMT_W-1 = 15)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  controller can accept request
req_op  in  3  ALU opcode (000 ADD, 001 SUB, 010 AND, 011 ORR, 100 NOT, 101 XOR, 110 LSR, 111 LSL)
req_a  in  16  operand A
req_b  in  16  operand B (ignored for NOT/LSR/LSL)
req_shamt  in  SHAMT_W  shift count, used only for 110/111
req_setf  in  1  1 = update flag register with this op's flags
alu_a  out  16  ALU operand A
alu_b  out  16  ALU operand B
alu_op  out  3  ALU opcode
alu_o  in  16  ALU result
alu_fc  in  1  ALU carry
alu_fv  in  1  ALU overflow
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_result  out  16  registered result
flags  out  4  flag register {Z,C,N,V}
busy  out  1  state != IDLE

Behaviour:
- Reset (sync, active-high): state=IDLE, rsp_valid=0, rsp_result=0, flags=0, internal acc/cnt/latched operands=0; req_ready=1, busy=0. Reset in any state aborts the operation with no response and no flag update.
- Accept = req_valid & req_ready at an edge; latch op, a, b, shamt, setf. req_ready=1 only in IDLE.
- States IDLE, EXEC, SHIFT, RESP:
  - IDLE: alu_a=0, alu_b=0, alu_op=000. On accept: op not 110/111 -> EXEC; shift with shamt=0 -> RESP directly, rsp_result=a, flags (if setf) Z=(a==0), C=0, N=a[15], V=0; shift with shamt>0 -> acc=a, cnt=shamt, SHIFT.
  - EXEC (1 cycle): alu_a=lat_a, alu_b=lat_b, alu_op=lat_op; at edge rsp_result<=alu_o, flags (if setf)<=computed; -> RESP.
  - SHIFT: alu_a=acc, alu_b=0, alu_op=lat_op; each edge acc<=alu_o, cnt<=cnt-1; on edge where cnt==1 also rsp_result<=alu_o, flags (if setf)<=computed, -> RESP.
  - RESP: rsp_valid=1; rsp_result and flags stable; req_valid ignored; on rsp_ready -> IDLE (rsp_valid=0 next cycle).
- Flag computation: Z=(alu_o==0) and N=alu_o[15] computed locally from alu_o; C=alu_fc, V=alu_fv. ALU Z/N outputs are not used.
- setf=0: flags hold previous value.
- Latency (accept edge -> rsp_valid high): non-shift 2 edges; shift shamt edges +1; shamt=0 1 edge.
- Throughput: one op outstanding; next accept no earlier than the cycle after the response handshake.
- Widths: all data 16-bit, no extension; shifts fill with 0; shifted-out bits discarded (C=0 for shifts).

Test Plan:
- ADD a=0x7FFF b=0x0001 setf=1 -> rsp_result=0x8000, flags Z0 C0 N1 V1, rsp_valid 2 edges after accept.
- ADD a=0xFFFF b=0x0001 setf=1 -> 0x0000, Z1 C1 N0 V0; then AND a=0x00F0 b=0x0F00 setf=0 -> result 0x0000, flags unchanged {1,1,0,0}.
- LSL a=0x0001 shamt=15 setf=1 -> 0x8000 after 16 edges, N1 Z0 C0; LSR a=0x1234 shamt=0 -> 0x1234 after 1 edge; LSR a=0x8000 shamt=4 -> 0x0800 after 5 edges.
- Backpressure: rsp_ready=0 for 5 cycles with req_valid=1 -> rsp_valid, rsp_result, flags stable, req_ready=0, no new accept; rsp_ready=1 -> IDLE next cycle, then accept.
- Reset asserted in SHIFT (LSL shamt=10, 3 edges in) -> next cycle IDLE, rsp_valid=0, flags=0, req_ready=1; no stray response afterward.
- SUB a=0x8000 b=0x0001 setf=1 -> 0x7FFF, V1 N0 Z0; NOT a=0x00FF -> 0xFF00, C0 V0.
